tv_checker: RTL and testbench

- Response checker paired with the 2-input test-vector generator; the other end of the vector stimulus interface.
- Observes the applied vector {in1,in0} and the gate-under-test output dut_out on the divided clock div_clk.
- Compares each response against the expected truth table for a selected gate type and counts passes and failures.
- Reports a pass/fail verdict after a programmed number of full 00→01→10→11 sweeps.

---
 rtl/tv_checker.sv | 226 ++++++++++++++++++++++
 tb/tb_tv_checker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tv_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tv_checker                                                    |
// | Description : Response checker for a 2-input gate driven by a sweeping      |
// |               00->01->10->11 test-vector generator. It syncs to vector 00,  |
// |               judges each applied vector one div_clk later against the      |
// |               truth table of the latched gate type, counts matches and      |
// |               mismatches (saturating), flags order violations and gives a   |
// |               pass/fail verdict after NUM_ROUNDS full sweeps.               |
// | Parameters  : NUM_ROUNDS - sweeps per run (4*NUM_ROUNDS compares)           |
// |               CNT_W      - width of the pass/fail counters                  |
// | Ports       : rst          async active-low reset                           |
// |               div_clk      checker clock (generator's divided clock)        |
// |               en_i         run enable / abort / done acknowledge            |
// |               gate_sel_i   0 AND,1 OR,2 NAND,3 NOR,4 XOR,5 XNOR,6/7 invalid |
// |               in0_i,in1_i  applied vector bits                              |
// |               dut_out_i    gate-under-test response                         |
// |               busy_o       run in progress (SYNC or CHECK)                  |
// |               done_o       run complete                                     |
// |               pass_o       verdict, valid while done_o                      |
// |               seq_err_o    sticky vector-order violation                    |
// |               pass_cnt_o   matching compares                                |
// |               fail_cnt_o   mismatching compares                             |
// | Option      : TV_CHECKER_ERR_LOG_EN adds first_fail_vec_o / first_fail_vld_o|
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tv_checker #(
   parameter int NUM_ROUNDS = 4,
   parameter int CNT_W      = 8
) (
   input  logic             rst,
   input  logic             div_clk,
   input  logic             en_i,
   input  logic [2:0]       gate_sel_i,
   input  logic             in0_i,
   input  logic             in1_i,
   input  logic             dut_out_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic             seq_err_o,
   output logic [CNT_W-1:0] pass_cnt_o,
`ifdef TV_CHECKER_ERR_LOG_EN
   output logic [CNT_W-1:0] fail_cnt_o,
   output logic [1:0]       first_fail_vec_o,
   output logic             first_fail_vld_o
`else
   output logic [CNT_W-1:0] fail_cnt_o
`endif
);

   localparam int               c_TOTAL   = 4 * NUM_ROUNDS;
   localparam int               c_CMP_W   = $clog2(c_TOTAL + 1);
   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_SYNC  = 2'd1;
   localparam logic [1:0] c_ST_CHECK = 2'd2;
   localparam logic [1:0] c_ST_DONE  = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [2:0]         sel_q, sel_d;
   logic [1:0]         prev_vec_q, prev_vec_d;
   logic [c_CMP_W-1:0] cmp_cnt_q, cmp_cnt_d;
   logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
   logic               seq_err_q, seq_err_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic [1:0]         ff_vec_q, ff_vec_d;
   logic               ff_vld_q, ff_vld_d;

   logic [1:0]         w_vec;
   logic               w_expected;
   logic               w_sel_ok;
   logic               w_match;
   logic               w_last_cmp;

   assign w_vec      = {in1_i, in0_i};
   assign w_last_cmp = (cmp_cnt_q == c_CMP_W'(c_TOTAL - 1));

   // Expected response for the vector applied one edge earlier.
   always_comb begin
      w_expected = 1'b0;
      w_sel_ok   = 1'b1;
      case (sel_q)
         3'd0:    w_expected =   prev_vec_q[1] & prev_vec_q[0];
         3'd1:    w_expected =   prev_vec_q[1] | prev_vec_q[0];
         3'd2:    w_expected = ~(prev_vec_q[1] & prev_vec_q[0]);
         3'd3:    w_expected = ~(prev_vec_q[1] | prev_vec_q[0]);
         3'd4:    w_expected =   prev_vec_q[1] ^ prev_vec_q[0];
         3'd5:    w_expected = ~(prev_vec_q[1] ^ prev_vec_q[0]);
         default: w_sel_ok   = 1'b0;
      endcase
   end

   // Unsupported gate types can never match.
   assign w_match = w_sel_ok && (dut_out_i == w_expected);

   // State register
   always_ff @(posedge div_clk or negedge rst) begin
      if (!rst) begin
         state_q <= c_ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_ST_IDLE: begin
            if (en_i) state_d = c_ST_SYNC;
         end
         c_ST_SYNC: begin
            if (!en_i)                state_d = c_ST_IDLE;
            else if (w_vec == 2'b00)  state_d = c_ST_CHECK;
         end
         c_ST_CHECK: begin
            if (!en_i)           state_d = c_ST_IDLE;
            else if (w_last_cmp) state_d = c_ST_DONE;
         end
         default: begin
            if (!en_i) state_d = c_ST_IDLE;
         end
      endcase
   end

   // Output and datapath next values
   always_comb begin
      sel_d      = sel_q;
      prev_vec_d = prev_vec_q;
      cmp_cnt_d  = cmp_cnt_q;
      pass_cnt_d = pass_cnt_q;
      fail_cnt_d = fail_cnt_q;
      seq_err_d  = seq_err_q;
      ff_vec_d   = ff_vec_q;
      ff_vld_d   = ff_vld_q;
      case (state_q)
         c_ST_IDLE: begin
            if (en_i) begin
               sel_d      = gate_sel_i;
               cmp_cnt_d  = '0;
               pass_cnt_d = '0;
               fail_cnt_d = '0;
               seq_err_d  = 1'b0;
               ff_vec_d   = 2'b00;
               ff_vld_d   = 1'b0;
            end
         end
         c_ST_SYNC: begin
            if (en_i && (w_vec == 2'b00)) prev_vec_d = 2'b00;
         end
         c_ST_CHECK: begin
            if (en_i) begin
               if (w_match) begin
                  if (pass_cnt_q != c_CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_W'(1);
               end else begin
                  if (fail_cnt_q != c_CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_W'(1);
                  if (!ff_vld_q) begin
                     ff_vld_d = 1'b1;
                     ff_vec_d = prev_vec_q;
                  end
               end
               // 2-bit add wraps 11 back to 00.
               if (w_vec != prev_vec_q + 2'd1) seq_err_d = 1'b1;
               prev_vec_d = w_vec;
               cmp_cnt_d  = cmp_cnt_q + c_CMP_W'(1);
            end
         end
         default: begin
         end
      endcase
      busy_d = (state_d == c_ST_SYNC) || (state_d == c_ST_CHECK);
      done_d = (state_d == c_ST_DONE);
      pass_d = done_d && (fail_cnt_d == '0) && !seq_err_d;
   end

   always_ff @(posedge div_clk or negedge rst) begin
      if (!rst) begin
         sel_q      <= 3'd0;
         prev_vec_q <= 2'b00;
         cmp_cnt_q  <= '0;
         pass_cnt_q <= '0;
         fail_cnt_q <= '0;
         seq_err_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         ff_vec_q   <= 2'b00;
         ff_vld_q   <= 1'b0;
      end else begin
         sel_q      <= sel_d;
         prev_vec_q <= prev_vec_d;
         cmp_cnt_q  <= cmp_cnt_d;
         pass_cnt_q <= pass_cnt_d;
         fail_cnt_q <= fail_cnt_d;
         seq_err_q  <= seq_err_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         ff_vec_q   <= ff_vec_d;
         ff_vld_q   <= ff_vld_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign pass_o     = pass_q;
   assign seq_err_o  = seq_err_q;
   assign pass_cnt_o = pass_cnt_q;
   assign fail_cnt_o = fail_cnt_q;

`ifdef TV_CHECKER_ERR_LOG_EN
   assign first_fail_vec_o = ff_vec_q;
   assign first_fail_vld_o = ff_vld_q;
`else
   // The log registers only feed the optional ports; keep them observable-free.
   logic w_unused_log;
   assign w_unused_log = ^{ff_vec_q, ff_vld_q};
`endif

endmodule
`default_nettype wire

// File: tb/tb_tv_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tv_checker                                                 |
// | Description : Self-checking bench for tv_checker. Drives vector sweeps and  |
// |               gate responses, records what the checker samples each edge,   |
// |               and derives the expected counts/flags from the truth tables.  |
// |               Two instances: CNT_W=8 and CNT_W=3 (saturation).              |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_tv_checker;

   localparam int ROUNDS = 4;

   logic       div_clk  = 1'b0;
   logic       rst      = 1'b0;
   logic       en       = 1'b0;
   logic [2:0] gate_sel = 3'd0;
   logic       in0      = 1'b0;
   logic       in1      = 1'b0;
   logic       dut_out  = 1'b0;

   logic       busy8, done8, pass8, seq8;
   logic [7:0] pcnt8, fcnt8;
   logic       busy3, done3, pass3, seq3;
   logic [2:0] pcnt3, fcnt3;
`ifdef TV_CHECKER_ERR_LOG_EN
   logic [1:0] ffv8, ffv3;
   logic       ffl8, ffl3;
`endif

   int n_checks = 0;
   int n_errs   = 0;

   bit [1:0] vs[$];
   bit       ds[$];

   int  e_np, e_nf;
   bit  e_sq;

   tv_checker #(.NUM_ROUNDS(ROUNDS), .CNT_W(8)) u_dut8 (
      .rst(rst), .div_clk(div_clk), .en_i(en), .gate_sel_i(gate_sel),
      .in0_i(in0), .in1_i(in1), .dut_out_i(dut_out),
      .busy_o(busy8), .done_o(done8), .pass_o(pass8), .seq_err_o(seq8),
`ifdef TV_CHECKER_ERR_LOG_EN
      .pass_cnt_o(pcnt8), .fail_cnt_o(fcnt8),
      .first_fail_vec_o(ffv8), .first_fail_vld_o(ffl8)
`else
      .pass_cnt_o(pcnt8), .fail_cnt_o(fcnt8)
`endif
   );

   tv_checker #(.NUM_ROUNDS(ROUNDS), .CNT_W(3)) u_dut3 (
      .rst(rst), .div_clk(div_clk), .en_i(en), .gate_sel_i(gate_sel),
      .in0_i(in0), .in1_i(in1), .dut_out_i(dut_out),
      .busy_o(busy3), .done_o(done3), .pass_o(pass3), .seq_err_o(seq3),
`ifdef TV_CHECKER_ERR_LOG_EN
      .pass_cnt_o(pcnt3), .fail_cnt_o(fcnt3),
      .first_fail_vec_o(ffv3), .first_fail_vld_o(ffl3)
`else
      .pass_cnt_o(pcnt3), .fail_cnt_o(fcnt3)
`endif
   );

   always #5 div_clk = ~div_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Truth table by number of ones in the vector.
   function automatic bit gate_ref(input int sel, input bit [1:0] v);
      int ones;
      ones = int'(v[1]) + int'(v[0]);
      case (sel)
         0: return ones == 2;
         1: return ones > 0;
         2: return ones != 2;
         3: return ones == 0;
         4: return ones == 1;
         5: return ones != 1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int sat(input int x, input int w);
      int m;
      m = (1 << w) - 1;
      return (x > m) ? m : x;
   endfunction

   // Drive inputs, then let one posedge consume them; returns at the next negedge.
   task automatic step(input bit e, input bit [1:0] v, input bit d);
      en      = e;
      in1     = v[1];
      in0     = v[0];
      dut_out = d;
      @(negedge div_clk);
   endtask

   // Expected results from the recorded per-edge samples of the run.
   task automatic check_run(input string tag, input int sel);
      int s, last, n;
      bit cmpl, fv;
      bit [1:0] fvec;
      n = vs.size();
      s = -1;
      for (int i = 0; i < n; i++) if (s < 0 && vs[i] == 2'b00) s = i;
      e_np = 0; e_nf = 0; e_sq = 0; cmpl = 0; fv = 0; fvec = 2'b00;
      if (s >= 0) begin
         last = s + 4 * ROUNDS;
         if (last <= n - 1) cmpl = 1; else last = n - 1;
         for (int i = s + 1; i <= last; i++) begin
            if (sel < 6 && ds[i] == gate_ref(sel, vs[i-1])) e_np++;
            else begin
               e_nf++;
               if (!fv) begin fv = 1; fvec = vs[i-1]; end
            end
            if (int'(vs[i]) != (int'(vs[i-1]) + 1) % 4) e_sq = 1;
         end
      end
      chk({tag, ".busy"},  32'(busy8), 32'(!cmpl));
      chk({tag, ".done"},  32'(done8), 32'(cmpl));
      chk({tag, ".pass"},  32'(pass8), 32'(cmpl && e_nf == 0 && !e_sq));
      chk({tag, ".seq"},   32'(seq8),  32'(e_sq));
      chk({tag, ".pcnt"},  32'(pcnt8), 32'(sat(e_np, 8)));
      chk({tag, ".fcnt"},  32'(fcnt8), 32'(sat(e_nf, 8)));
      chk({tag, ".busy3"}, 32'(busy3), 32'(!cmpl));
      chk({tag, ".done3"}, 32'(done3), 32'(cmpl));
      chk({tag, ".pass3"}, 32'(pass3), 32'(cmpl && e_nf == 0 && !e_sq));
      chk({tag, ".seq3"},  32'(seq3),  32'(e_sq));
      chk({tag, ".pcnt3"}, 32'(pcnt3), 32'(sat(e_np, 3)));
      chk({tag, ".fcnt3"}, 32'(fcnt3), 32'(sat(e_nf, 3)));
`ifdef TV_CHECKER_ERR_LOG_EN
      chk({tag, ".ffl"}, 32'(ffl8), 32'(fv));
      if (fv) chk({tag, ".ffv"}, 32'(ffv8), 32'(fvec));
      chk({tag, ".ffl3"}, 32'(ffl3), 32'(fv));
      if (fv) chk({tag, ".ffv3"}, 32'(ffv3), 32'(fvec));
`endif
   endtask

   // One run: enable at vector 'start', then n generator edges. Mode 0 correct
   // gate (random for invalid sel), 1 stuck-at-1, 2 correct with random flips.
   // skip >= 0 makes the generator jump two vectors at that edge.
   task automatic run(input string tag, input int sel, input int start, input int n,
                      input int mode, input int skip, input bit drop);
      bit [1:0] v, nv;
      bit d;
      gate_sel = 3'(sel);
      v = 2'(start);
      step(1'b1, v, 1'b0);
      gate_sel = 3'($urandom_range(0, 7));
      vs.delete();
      ds.delete();
      for (int k = 0; k < n; k++) begin
         nv = (k == skip) ? v + 2'd2 : v + 2'd1;
         case (mode)
            0:       d = (sel < 6) ? gate_ref(sel, v) : 1'($urandom_range(0, 1));
            1:       d = 1'b1;
            default: d = gate_ref(sel, v) ^ ($urandom_range(0, 4) == 0);
         endcase
         step(1'b1, nv, d);
         vs.push_back(nv);
         ds.push_back(d);
         v = nv;
      end
      check_run(tag, sel);
      if (drop) begin
         step(1'b0, v, 1'b0);
         chk({tag, ".idle_busy"}, 32'(busy8), 32'd0);
         chk({tag, ".idle_done"}, 32'(done8), 32'd0);
         chk({tag, ".idle_pcnt"}, 32'(pcnt8), 32'(sat(e_np, 8)));
         chk({tag, ".idle_fcnt"}, 32'(fcnt8), 32'(sat(e_nf, 8)));
         chk({tag, ".idle_seq"},  32'(seq8),  32'(e_sq));
      end
   endtask

   initial begin
      int sel, st, n, mode, skip;
      // Reset state
      repeat (2) @(negedge div_clk);
      chk("rst.busy", 32'(busy8), 32'd0);
      chk("rst.done", 32'(done8), 32'd0);
      chk("rst.pass", 32'(pass8), 32'd0);
      chk("rst.seq",  32'(seq8),  32'd0);
      chk("rst.pcnt", 32'(pcnt8), 32'd0);
      chk("rst.fcnt", 32'(fcnt8), 32'd0);
      rst = 1'b1;
      step(1'b0, 2'b00, 1'b0);

      run("and_ok",     0, 3, 17, 0, -1, 1'b1);
      run("xor_stuck1", 4, 3, 17, 1, -1, 1'b1);
      run("late_sync",  0, 1, 19, 0, -1, 1'b1);
      run("nor_order",  3, 3, 17, 0,  2, 1'b1);
      run("sel7",       7, 3, 17, 0, -1, 1'b1);
      run("hold_done",  5, 2, 22, 0, -1, 1'b1);

      for (int r = 0; r < 10; r++) begin
         sel  = $urandom_range(0, 7);
         st   = $urandom_range(0, 3);
         n    = $urandom_range(8, 22);
         mode = $urandom_range(0, 2);
         skip = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
         run($sformatf("rand%0d", r), sel, st, n, mode, skip, 1'b1);
      end

      // Abort after 5 compares
      run("abort", 0, 3, 6, 0, -1, 1'b1);

      // Asynchronous reset in the middle of CHECK
      run("midrst", 1, 3, 4, 0, -1, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk("arst.busy",  32'(busy8), 32'd0);
      chk("arst.pcnt",  32'(pcnt8), 32'd0);
      chk("arst.fcnt",  32'(fcnt8), 32'd0);
      chk("arst.busy3", 32'(busy3), 32'd0);
      chk("arst.pcnt3", 32'(pcnt3), 32'd0);
      en = 1'b0;
      @(negedge div_clk);
      rst = 1'b1;
      step(1'b0, 2'b00, 1'b0);
      chk("post.busy", 32'(busy8), 32'd0);
      chk("post.done", 32'(done8), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
`default_nettype wire
